// File: rtl/regfile_dump.sv
// regfile_dump: walks a register index range through one read port
// and streams each value out over a valid/ready handshake.
module regfile_dump #(
  parameter logic SKIP_R0 = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [4:0]  First,
  input  logic [4:0]  Last,
  output logic [4:0]  RA,
  input  logic [31:0] PA,
  output logic [31:0] Dout,
  output logic [4:0]  Dout_Idx,
  output logic        Valid,
  input  logic        Ready,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    OUT,
    DONE
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] idx_q;
  logic [4:0] last_q;
  logic       skip;
  logic       at_last;
  logic       hs;

  // r0 is dropped without a bus cycle when the parameter asks
  assign skip    = SKIP_R0 && (idx_q == 5'd0);
  assign at_last = (idx_q == last_q);
  assign hs      = Valid && Ready;

  // state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (Start) state_d = READ;
      end
      state_q == READ: begin
        if (!skip)        state_d = OUT;
        else if (at_last) state_d = DONE;
      end
      state_q == OUT: begin
        if (hs) state_d = at_last ? DONE : READ;
      end
      state_q == DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // index walk, range latch and output word capture
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      idx_q    <= 5'd0;
      last_q   <= 5'd0;
      Dout     <= 32'd0;
      Dout_Idx <= 5'd0;
      Valid    <= 1'b0;
    end else begin
      unique case (1'b1)
        state_q == IDLE: begin
          if (Start) begin
            idx_q  <= First;
            last_q <= Last;
          end
        end
        state_q == READ: begin
          if (!skip) begin
            Dout     <= PA;
            Dout_Idx <= idx_q;
            Valid    <= 1'b1;
          end else if (!at_last) begin
            idx_q <= idx_q + 5'd1;
          end
        end
        state_q == OUT: begin
          if (hs) begin
            Valid <= 1'b0;
            if (!at_last) idx_q <= idx_q + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // read address and status flags from state
  always_comb begin
    RA   = 5'd0;
    Busy = (state_q != IDLE);
    Done = (state_q == DONE);
    if (state_q == READ || state_q == OUT) RA = idx_q;
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed vectors for regfile_dump,
// one DUT per SKIP_R0 setting behind a shared register file.
module tb_regfile_dump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  first;
  logic [4:0]  last;
  logic        ready;
  logic        sel;
  logic [31:0] regs [32];

  logic        m_start, s_start;
  logic [4:0]  m_ra, s_ra;
  logic [31:0] m_pa, s_pa;
  logic [31:0] m_dout, s_dout;
  logic [4:0]  m_didx, s_didx;
  logic        m_valid, s_valid;
  logic        m_busy, s_busy;
  logic        m_done, s_done;

  logic [4:0]  ra;
  logic [31:0] dout;
  logic [4:0]  dout_idx;
  logic        valid;
  logic        busy;
  logic        done;

  int n_chk;
  int n_fail;

  logic [4:0]  widx [$];
  logic [31:0] wval [$];
  int          wcyc [$];
  int          vcnt;
  int          done_cyc;

  assign m_start = start & ~sel;
  assign s_start = start & sel;
  assign m_pa    = regs[m_ra];
  assign s_pa    = regs[s_ra];

  assign ra       = sel ? s_ra    : m_ra;
  assign dout     = sel ? s_dout  : m_dout;
  assign dout_idx = sel ? s_didx  : m_didx;
  assign valid    = sel ? s_valid : m_valid;
  assign busy     = sel ? s_busy  : m_busy;
  assign done     = sel ? s_done  : m_done;

  regfile_dump #(.SKIP_R0(1'b0)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(m_start),
    .First(first), .Last(last), .RA(m_ra), .PA(m_pa),
    .Dout(m_dout), .Dout_Idx(m_didx), .Valid(m_valid),
    .Ready(ready), .Busy(m_busy), .Done(m_done)
  );

  regfile_dump #(.SKIP_R0(1'b1)) dut_s (
    .Clk(clk), .Rst_n(rst_n), .Start(s_start),
    .First(first), .Last(last), .RA(s_ra), .PA(s_pa),
    .Dout(s_dout), .Dout_Idx(s_didx), .Valid(s_valid),
    .Ready(ready), .Busy(s_busy), .Done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run(input logic s, input logic [4:0] f,
                     input logic [4:0] l, input int hw,
                     input int hl, input logic poke);
    int st;
    logic dn;
    logic [4:0] hi;
    logic [31:0] hv;
    sel = s;
    widx.delete(); wval.delete(); wcyc.delete();
    vcnt = 0; done_cyc = 0; st = 0; dn = 1'b0;
    hi = 5'd0; hv = 32'd0;
    first = f; last = l; ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 200 && !dn; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_read", 32'(busy), 32'd1);
        check("valid_read", 32'(valid), 32'd0);
      end
      if (poke && cyc == 3) begin
        start = 1'b1; first = 5'd20; last = 5'd25;
      end
      if (poke && cyc == 6) start = 1'b0;
      if (done) begin
        dn = 1'b1; done_cyc = cyc;
      end
      if (valid) vcnt++;
      ready = 1'b1;
      if (valid && widx.size() == hw && st < hl) begin
        ready = 1'b0;
        if (st == 0) begin
          hi = dout_idx; hv = dout;
        end else begin
          check("bp_dout", dout, hv);
          check("bp_idx", 32'(dout_idx), 32'(hi));
          check("bp_ra", 32'(ra), 32'(hi));
        end
        st++;
      end
      if (valid && ready) begin
        if (hl > 0 && st == hl && widx.size() == hw) begin
          check("bp_rel_dout", dout, hv);
          check("bp_rel_idx", 32'(dout_idx), 32'(hi));
        end
        widx.push_back(dout_idx);
        wval.push_back(dout);
        wcyc.push_back(cyc);
      end
    end
    if (!dn) check("timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic expect_seq(input string tag,
                            input logic [4:0] f0, input int n);
    logic [4:0] e;
    check({tag, "_count"}, 32'(widx.size()), 32'(n));
    for (int k = 0; k < n && k < widx.size(); k++) begin
      e = f0 + 5'(k);
      check({tag, "_idx"}, 32'(widx[k]), 32'(e));
      check({tag, "_val"}, wval[k], 32'(e) * 32'h01010101);
    end
    if (n > 0 && widx.size() > 0)
      check({tag, "_done_lat"}, 32'(done_cyc),
            32'(wcyc[wcyc.size() - 1] + 1));
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 32; i++)
      regs[i] = 32'(i) * 32'h01010101;
    sel = 1'b0; start = 1'b0; ready = 1'b0;
    first = 5'd0; last = 5'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_ra", 32'(m_ra), 32'd0);
    check("rst_dout", m_dout, 32'd0);
    check("rst_didx", 32'(m_didx), 32'd0);
    check("rst_s_busy", 32'(s_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run(1'b0, 5'd0, 5'd31, -1, 0, 1'b0);
    expect_seq("full", 5'd0, 32);
    check("full_vcnt", 32'(vcnt), 32'd32);
    for (int k = 0; k < wcyc.size(); k++)
      check("full_cadence", 32'(wcyc[k]), 32'(2 + 2 * k));

    run(1'b0, 5'd30, 5'd1, -1, 0, 1'b0);
    expect_seq("wrap", 5'd30, 4);

    run(1'b0, 5'd10, 5'd13, 1, 5, 1'b0);
    expect_seq("bp", 5'd10, 4);

    run(1'b1, 5'd0, 5'd2, -1, 0, 1'b0);
    expect_seq("skip", 5'd1, 2);

    run(1'b1, 5'd0, 5'd0, -1, 0, 1'b0);
    expect_seq("skip0", 5'd0, 0);
    check("skip0_vcnt", 32'(vcnt), 32'd0);
    check("skip0_done", 32'(done_cyc), 32'd2);

    run(1'b0, 5'd3, 5'd6, -1, 0, 1'b1);
    expect_seq("poke", 5'd3, 4);

    sel = 1'b0; first = 5'd0; last = 5'd31;
    ready = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_valid_pre", 32'(valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_ra", 32'(ra), 32'd0);
    check("rst_mid_dout", dout, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    run(1'b0, 5'd5, 5'd5, -1, 0, 1'b0);
    expect_seq("single", 5'd5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
